// File: rtl/pt_frame_sched_if.sv
// Byte-stream / encoder handshake bundle for pt_frame_sched.
// master drives the UART byte strobes and encoder done; slave is the sequencer.
interface pt_frame_sched_if #(
  parameter int unsigned CNT_W = 16
);
  logic             byte_valid;
  logic [7:0]       byte_in;
  logic             abort;
  logic             enc_done;
  logic             byte_ready;
  logic             enc_run;
  logic [23:0]      enc_payload;
  logic             busy;
  logic             overrun;
  logic             timeout;
  logic [CNT_W-1:0] frames_sent;

  modport master (
    output byte_valid, byte_in, abort, enc_done,
    input  byte_ready, enc_run, enc_payload, busy, overrun, timeout, frames_sent
  );

  modport slave (
    input  byte_valid, byte_in, abort, enc_done,
    output byte_ready, enc_run, enc_payload, busy, overrun, timeout, frames_sent
  );
endinterface

// File: rtl/pt_frame_sched.sv
// Collects 3 UART bytes into a 24-bit PT2262 word and holds pt_enc running for REPEAT words.
// Optional inter-byte timeout is built only when PT_SCHED_TIMEOUT_EN is defined.
module pt_frame_sched #(
  parameter int unsigned REPEAT         = 6,
  parameter int unsigned TIMEOUT_CYCLES = 2000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  pt_frame_sched_if.slave  bus
);

  if (REPEAT < 1 || REPEAT > 255) begin : g_bad_repeat
    $error("pt_frame_sched: REPEAT must be within 1..255");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("pt_frame_sched: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic {COLLECT = 1'b0, SEND = 1'b1} state_t;

  state_t           r_state;
  logic [1:0]       r_byte_idx;
  logic [7:0]       r_rep_cnt;
  logic [15:0]      r_hi;
  logic [23:0]      r_payload;
  logic             r_enc_run;
  logic             r_busy;
  logic             r_byte_ready;
  logic             r_overrun;
  logic [CNT_W-1:0] r_frames;

  logic             w_accept;
  logic             w_to_fire;
  logic [1:0]       w_idx_eff;

  assign w_accept  = (r_state == COLLECT) && bus.byte_valid && r_byte_ready && !bus.abort;
  // A timeout in the same cycle as a byte restarts the frame with that byte as byte 0.
  assign w_idx_eff = w_to_fire ? 2'd0 : r_byte_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= COLLECT;
      r_byte_idx   <= '0;
      r_rep_cnt    <= '0;
      r_hi         <= '0;
      r_payload    <= '0;
      r_enc_run    <= 1'b0;
      r_busy       <= 1'b0;
      r_byte_ready <= 1'b0;
      r_overrun    <= 1'b0;
      r_frames     <= '0;
    end else begin
      r_overrun <= bus.byte_valid && !r_byte_ready && !bus.abort;
      case (r_state)
        COLLECT: begin
          r_byte_ready <= 1'b1;
          if (bus.abort) begin
            r_byte_idx <= '0;
          end else if (w_accept) begin
            case (w_idx_eff)
              2'd0: begin
                r_hi[15:8] <= bus.byte_in;
                r_byte_idx <= 2'd1;
              end
              2'd1: begin
                r_hi[7:0]  <= bus.byte_in;
                r_byte_idx <= 2'd2;
              end
              default: begin
                r_payload    <= {r_hi, bus.byte_in};
                r_rep_cnt    <= '0;
                r_byte_idx   <= '0;
                r_state      <= SEND;
                r_byte_ready <= 1'b0;
                r_enc_run    <= 1'b1;
                r_busy       <= 1'b1;
              end
            endcase
          end else begin
            r_byte_idx <= w_idx_eff;
          end
        end
        SEND: begin
          if (bus.abort) begin
            r_state      <= COLLECT;
            r_enc_run    <= 1'b0;
            r_busy       <= 1'b0;
            r_byte_ready <= 1'b1;
            r_byte_idx   <= '0;
          end else if (bus.enc_done) begin
            if (r_rep_cnt == 8'(REPEAT - 1)) begin
              r_state      <= COLLECT;
              r_enc_run    <= 1'b0;
              r_busy       <= 1'b0;
              r_byte_ready <= 1'b1;
              r_byte_idx   <= '0;
              r_frames     <= r_frames + 1'b1;
            end else begin
              r_rep_cnt <= r_rep_cnt + 8'd1;
            end
          end
        end
      endcase
    end
  end

`ifdef PT_SCHED_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES);

  logic [IDLE_W-1:0] r_idle;
  logic              r_timeout;

  // Fires on the edge where the idle count would reach TIMEOUT_CYCLES-1.
  assign w_to_fire = (r_state == COLLECT) && (r_byte_idx != 2'd0) && !bus.abort &&
                     (r_idle == IDLE_W'(TIMEOUT_CYCLES - 2));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idle    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_to_fire;
      if ((r_state != COLLECT) || bus.abort || w_accept || w_to_fire || (r_byte_idx == 2'd0))
        r_idle <= '0;
      else
        r_idle <= r_idle + 1'b1;
    end
  end

  assign bus.timeout = r_timeout;
`else
  assign w_to_fire   = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  assign bus.byte_ready  = r_byte_ready;
  assign bus.enc_run     = r_enc_run;
  assign bus.enc_payload = r_payload;
  assign bus.busy        = r_busy;
  assign bus.overrun     = r_overrun;
  assign bus.frames_sent = r_frames;

endmodule

// File: tb/tb_pt_frame_sched.sv
// Randomised and directed bench for pt_frame_sched: two instances (REPEAT=6/CNT_W=16 and
// REPEAT=1/CNT_W=4) share one stimulus stream and are compared every cycle to a frame-level model.
module tb_pt_frame_sched;
  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       t_bv = 1'b0;
  logic [7:0] t_bi = 8'h00;
  logic       t_ab = 1'b0;
  logic       t_ed = 1'b0;

  pt_frame_sched_if #(.CNT_W(16)) ifa ();
  pt_frame_sched_if #(.CNT_W(4))  ifb ();

  assign ifa.byte_valid = t_bv;
  assign ifa.byte_in    = t_bi;
  assign ifa.abort      = t_ab;
  assign ifa.enc_done   = t_ed;
  assign ifb.byte_valid = t_bv;
  assign ifb.byte_in    = t_bi;
  assign ifb.abort      = t_ab;
  assign ifb.enc_done   = t_ed;

  pt_frame_sched #(.REPEAT(6), .TIMEOUT_CYCLES(TO), .CNT_W(16)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  pt_frame_sched #(.REPEAT(1), .TIMEOUT_CYCLES(TO), .CNT_W(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame-level reference: bytes accumulate into a 24-bit word, a frame ends after REPEAT dones.
  int m_rep [2] = '{6, 1};
  int m_mod [2] = '{65536, 16};
  bit m_send [2], m_ready [2], m_ovr [2], m_to [2];
  int m_nb [2], m_acc [2], m_payload [2], m_frames [2], m_dones [2], m_idle [2];

  task automatic model_step(input int i);
    bit acc;
    m_ovr[i] = 1'b0;
    m_to[i]  = 1'b0;
    if (rst) begin
      m_send[i] = 0; m_ready[i] = 0; m_nb[i] = 0; m_acc[i] = 0; m_payload[i] = 0;
      m_frames[i] = 0; m_dones[i] = 0; m_idle[i] = 0;
    end else begin
      m_ovr[i] = t_bv && !m_ready[i] && !t_ab;
      if (!m_send[i]) begin
        acc = t_bv && m_ready[i] && !t_ab;
        m_ready[i] = 1;
        if (t_ab) begin
          m_nb[i] = 0;
          m_idle[i] = 0;
        end else begin
`ifdef PT_SCHED_TIMEOUT_EN
          if (m_nb[i] > 0 && m_idle[i] + 1 == TO - 1) begin
            m_to[i] = 1; m_nb[i] = 0; m_idle[i] = 0;
          end else if (m_nb[i] > 0 && !acc) begin
            m_idle[i]++;
          end
`endif
          if (acc) begin
            m_idle[i] = 0;
            m_acc[i] = ((m_acc[i] << 8) | int'(t_bi)) & 32'h00FF_FFFF;
            m_nb[i]++;
            if (m_nb[i] == 3) begin
              m_payload[i] = m_acc[i];
              m_nb[i] = 0; m_send[i] = 1; m_ready[i] = 0; m_dones[i] = 0;
            end
          end
        end
      end else if (t_ab) begin
        m_send[i] = 0; m_ready[i] = 1;
      end else if (t_ed) begin
        m_dones[i]++;
        if (m_dones[i] == m_rep[i]) begin
          m_send[i] = 0; m_ready[i] = 1;
          m_frames[i] = (m_frames[i] + 1) % m_mod[i];
        end
      end
    end
  endtask

  task automatic compare_all();
    check("a.byte_ready",  32'(ifa.byte_ready),  32'(m_ready[0]));
    check("a.enc_run",     32'(ifa.enc_run),     32'(m_send[0]));
    check("a.busy",        32'(ifa.busy),        32'(m_send[0]));
    check("a.payload",     32'(ifa.enc_payload), m_payload[0]);
    check("a.overrun",     32'(ifa.overrun),     32'(m_ovr[0]));
    check("a.timeout",     32'(ifa.timeout),     32'(m_to[0]));
    check("a.frames_sent", 32'(ifa.frames_sent), m_frames[0]);
    check("b.byte_ready",  32'(ifb.byte_ready),  32'(m_ready[1]));
    check("b.enc_run",     32'(ifb.enc_run),     32'(m_send[1]));
    check("b.busy",        32'(ifb.busy),        32'(m_send[1]));
    check("b.payload",     32'(ifb.enc_payload), m_payload[1]);
    check("b.overrun",     32'(ifb.overrun),     32'(m_ovr[1]));
    check("b.timeout",     32'(ifb.timeout),     32'(m_to[1]));
    check("b.frames_sent", 32'(ifb.frames_sent), m_frames[1]);
  endtask

  task automatic tick(input logic bv, input logic [7:0] bi, input logic ab, input logic ed);
    t_bv = bv; t_bi = bi; t_ab = ab; t_ed = ed;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(0, 8'h00, 0, 0);
    tick(0, 8'h00, 0, 0);
    rst = 1'b0;
    tick(0, 8'h00, 0, 0);
  endtask

  task automatic send3(input logic [23:0] w);
    tick(1, w[23:16], 0, 0);
    tick(1, w[15:8],  0, 0);
    tick(1, w[7:0],   0, 0);
  endtask

  task automatic dones(input int n);
    for (int k = 0; k < n; k++) tick(0, 8'h00, 0, 1);
  endtask

  initial begin
    rst = 1'b1;
    tick(0, 8'h00, 0, 0);
    check("rst.byte_ready", 32'(ifa.byte_ready), 32'd0);
    check("rst.frames",     32'(ifa.frames_sent), 32'd0);
    rst = 1'b0;
    tick(0, 8'h00, 0, 0);
    check("rdy_after_rst", 32'(ifa.byte_ready), 32'd1);

    // Basic frame
    send3(24'hA53C0F);
    check("t1.payload", 32'(ifa.enc_payload), 32'h00A53C0F);
    check("t1.run",     32'(ifa.enc_run), 32'd1);
    dones(5);
    check("t1.run_held", 32'(ifa.enc_run), 32'd1);
    dones(1);
    check("t1.frames", 32'(ifa.frames_sent), 32'd1);
    check("t1.ready",  32'(ifa.byte_ready), 32'd1);

    // Byte while sending
    send3(24'h123456);
    tick(1, 8'h77, 0, 0);
    check("t2.overrun", 32'(ifa.overrun), 32'd1);
    tick(0, 8'h00, 0, 0);
    check("t2.overrun_end", 32'(ifa.overrun), 32'd0);
    check("t2.payload", 32'(ifa.enc_payload), 32'h00123456);
    dones(6);
    check("t2.frames", 32'(ifa.frames_sent), 32'd2);

    // Abort mid-send
    send3(24'hDEAD01);
    dones(2);
    tick(0, 8'h00, 1, 0);
    check("t3.run", 32'(ifa.enc_run), 32'd0);
    check("t3.frames", 32'(ifa.frames_sent), 32'd2);
    send3(24'h112233);
    check("t3.payload", 32'(ifa.enc_payload), 32'h00112233);
    dones(6);

    // Abort beats byte_valid with two bytes held
    tick(1, 8'hE1, 0, 0);
    tick(1, 8'hE2, 0, 0);
    tick(1, 8'h99, 1, 0);
    check("t4.overrun", 32'(ifa.overrun), 32'd0);
    check("t4.busy",    32'(ifa.busy), 32'd0);
    send3(24'h445566);
    check("t4.payload", 32'(ifa.enc_payload), 32'h00445566);
    dones(6);

`ifdef PT_SCHED_TIMEOUT_EN
    begin
      int first_to;
      int n_to;
      do_reset();
      first_to = -1;
      n_to = 0;
      tick(1, 8'hC3, 0, 0);
      for (int k = 1; k <= 25; k++) begin
        tick(0, 8'h00, 0, 0);
        if (ifa.timeout) begin
          n_to++;
          if (first_to < 0) first_to = k;
        end
      end
      check("t5.to_cycle", 32'(first_to), 32'd19);
      check("t5.to_count", 32'(n_to), 32'd1);
      send3(24'h0A0B0C);
      check("t5.payload", 32'(ifa.enc_payload), 32'h000A0B0C);
      dones(6);
    end
`endif

    // Randomised traffic with periodic idle gaps
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 200) begin
        for (int g = 0; g < 25; g++) tick(0, 8'h00, 0, 0);
      end
      tick(logic'($urandom_range(0, 99) < 30), 8'($urandom),
           logic'($urandom_range(0, 99) < 3), logic'($urandom_range(0, 99) < 25));
    end

    // Counter wrap on the 4-bit, REPEAT=1 instance
    do_reset();
    for (int f = 0; f < 17; f++) begin
      send3(24'($urandom));
      check("t6.run", 32'(ifb.enc_run), 32'd1);
      tick(0, 8'h00, 0, 1);
      check("t6.single_done", 32'(ifb.enc_run), 32'd0);
    end
    check("t6.wrap", 32'(ifb.frames_sent), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
